// File: rtl/gpu_raster_stage.sv
// gpu_raster_stage: primitive FIFO plus bounding-box scan emitting one fragment per pixel.
module gpu_raster_stage #(
  parameter int DEPTH    = 2,
  parameter int VERTEX_W = 30,
  parameter int GSR_W    = 6,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET_N,
  input  logic                I_LOCK,
  input  logic [GSR_W-1:0]    I_GSRValue,
  input  logic                I_GSRValue_Valid,
  input  logic [VERTEX_W-1:0] I_VertexV1,
  input  logic [VERTEX_W-1:0] I_VertexV2,
  input  logic [VERTEX_W-1:0] I_VertexV3,
  output logic                O_GPUStallSignal,
  output logic [9:0]          O_FragX,
  output logic [9:0]          O_FragY,
  output logic [2:0]          O_FragColor,
  output logic                O_FragValid,
  input  logic                I_FragReady,
  output logic                O_PrimDone,
  output logic                O_Overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] XM = 11'(SCREEN_W - 1);
  localparam logic [10:0] YM = 11'(SCREEN_H - 1);
  typedef enum logic [1:0] {IDLE, SETUP, RASTER} state_t;
  state_t state, state_nx;
  logic [62:0] mem [DEPTH];
  logic [62:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [10:0] x, y, min_x, max_x, max_y;
  logic [2:0] color;
  logic full, push, pop, fire, last, ovf;
  logic [9:0] vx [3];
  logic [9:0] vy [3];
  logic [10:0] raw_lx, raw_hx, raw_ly, raw_hy, lx, hx, ly, hy;
  logic unused_bits;
  function automatic logic [10:0] mn(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return {1'b0, (m < c) ? m : c};
  endfunction
  function automatic logic [10:0] mx(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return {1'b0, (m > c) ? m : c};
  endfunction
  // Only colour and X/Y are stored; attributes and upper GSR bits are never used downstream.
  assign unused_bits = ^{I_GSRValue[GSR_W-1:3], I_VertexV1[9:0], I_VertexV2[9:0], I_VertexV3[9:0]};
  assign head  = mem[rd_ptr];
  assign vx[0] = head[59:50];
  assign vy[0] = head[49:40];
  assign vx[1] = head[39:30];
  assign vy[1] = head[29:20];
  assign vx[2] = head[19:10];
  assign vy[2] = head[9:0];
  assign raw_lx = mn(vx[0], vx[1], vx[2]);
  assign raw_hx = mx(vx[0], vx[1], vx[2]);
  assign raw_ly = mn(vy[0], vy[1], vy[2]);
  assign raw_hy = mx(vy[0], vy[1], vy[2]);
  assign hx = (raw_hx > XM) ? XM : raw_hx;
  assign lx = (raw_lx > hx) ? hx : raw_lx;
  assign hy = (raw_hy > YM) ? YM : raw_hy;
  assign ly = (raw_ly > hy) ? hy : raw_ly;
  assign full = (count == (AW+1)'(DEPTH));
  assign fire = O_FragValid & I_FragReady;
  assign last = (x == max_x) && (y == max_y);
  assign pop  = fire & last;
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign push = I_GSRValue_Valid & (~full | pop);
  assign ovf  = I_GSRValue_Valid & full & ~pop;
  assign O_GPUStallSignal = full;
  assign O_FragX     = x[9:0];
  assign O_FragY     = y[9:0];
  assign O_FragColor = color;
  always_ff @(posedge I_CLOCK or negedge I_RESET_N)
    if (!I_RESET_N) state <= IDLE;
    else if (!I_LOCK) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE && count != '0) ? SETUP :
               (state == SETUP)               ? RASTER :
               (state == RASTER && pop)       ? IDLE : state;
  always_comb O_FragValid = (state == RASTER);
  always_ff @(posedge I_CLOCK)
    if (push && I_LOCK) mem[wr_ptr] <= {I_GSRValue[2:0], I_VertexV1[29:10], I_VertexV2[29:10], I_VertexV3[29:10]};
  always_ff @(posedge I_CLOCK or negedge I_RESET_N)
    if (!I_RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      O_Overflow <= 1'b0;
      O_PrimDone <= 1'b0;
    end else if (!I_LOCK) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      O_Overflow <= 1'b0;
      O_PrimDone <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      O_Overflow <= O_Overflow | ovf;
      O_PrimDone <= pop;
    end
  always_ff @(posedge I_CLOCK or negedge I_RESET_N)
    if (!I_RESET_N) begin
      x <= '0;
      y <= '0;
      min_x <= '0;
      max_x <= '0;
      max_y <= '0;
      color <= '0;
    end else if (!I_LOCK) begin
      x <= '0;
      y <= '0;
      min_x <= '0;
      max_x <= '0;
      max_y <= '0;
      color <= '0;
    end else if (state == SETUP) begin
      x <= lx;
      y <= ly;
      min_x <= lx;
      max_x <= hx;
      max_y <= hy;
      color <= head[62:60];
    end else if (fire) begin
      x <= (x == max_x) ? min_x : x + 11'd1;
      y <= (x == max_x) ? y + 11'd1 : y;
    end
endmodule

// File: tb/tb_gpu_raster_stage.sv
// tb_gpu_raster_stage: directed vector table plus hand sequences for stall, overflow, flush and reset.
module tb_gpu_raster_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lock = 1'b1;
  logic [5:0] gsr = '0;
  logic gv = 1'b0;
  logic [29:0] v1 = '0, v2 = '0, v3 = '0;
  logic stall, frag_valid, prim_done, overflow;
  logic frag_ready = 1'b1;
  logic [9:0] frag_x, frag_y;
  logic [2:0] frag_col;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [9:0] x1, y1, x2, y2, x3, y3;
    logic [5:0] gsr;
    int lx, hx, ly, hy, n, col;
  } vec_t;
  vec_t vecs [5];
  gpu_raster_stage dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock),
    .I_GSRValue(gsr), .I_GSRValue_Valid(gv),
    .I_VertexV1(v1), .I_VertexV2(v2), .I_VertexV3(v3),
    .O_GPUStallSignal(stall), .O_FragX(frag_x), .O_FragY(frag_y), .O_FragColor(frag_col),
    .O_FragValid(frag_valid), .I_FragReady(frag_ready), .O_PrimDone(prim_done), .O_Overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input vec_t v);
    gsr = v.gsr;
    v1 = {v.x1, v.y1, 10'h2A5};
    v2 = {v.x2, v.y2, 10'h15A};
    v3 = {v.x3, v.y3, 10'h3FF};
    gv = 1'b1;
    @(negedge clk);
    gv = 1'b0;
  endtask
  task automatic wait_valid();
    int w;
    w = 0;
    while (!frag_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
  endtask
  // Outputs are observed on negedges; ready set here applies to the following posedge.
  task automatic scan(input vec_t v, input bit toggle);
    int got, cyc, ex, ey;
    wait_valid();
    chk("scan_start", frag_valid, 1);
    ex = v.lx; ey = v.ly; got = 0; cyc = 0;
    while (got < v.n && cyc < 1000) begin
      chk("frag_valid", frag_valid, 1);
      chk("frag_x", frag_x, ex);
      chk("frag_y", frag_y, ey);
      chk("frag_col", frag_col, v.col);
      chk("done_low", prim_done, 0);
      frag_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (frag_ready) begin
        got++;
        if (ex == v.hx) begin ex = v.lx; ey++; end else ex++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("frag_count", got, v.n);
    chk("done_pulse", prim_done, 1);
    chk("valid_after", frag_valid, 0);
    @(negedge clk);
    chk("done_clear", prim_done, 0);
  endtask
  task automatic run(input vec_t v, input bit toggle);
    int lat;
    frag_ready = 1'b1;
    push(v);
    lat = 1;
    while (!frag_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    scan(v, toggle);
  endtask
  task automatic idle_check(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      seen += int'(frag_valid);
    end
    chk(name, seen, 0);
  endtask
  initial begin
    vecs[0] = '{x1:5,   y1:7,   x2:5,   y2:7,   x3:5,   y3:7,   gsr:3, lx:5,   hx:5,   ly:7,   hy:7,   n:1,   col:3};
    vecs[1] = '{x1:2,   y1:1,   x2:4,   y2:1,   x3:3,   y3:2,   gsr:5, lx:2,   hx:4,   ly:1,   hy:2,   n:6,   col:5};
    vecs[2] = '{x1:630, y1:470, x2:700, y2:479, x3:639, y3:500, gsr:6, lx:630, hx:639, ly:470, hy:479, n:100, col:6};
    vecs[3] = '{x1:700, y1:490, x2:650, y2:600, x3:800, y3:500, gsr:9, lx:639, hx:639, ly:479, hy:479, n:1,   col:1};
    vecs[4] = '{x1:10,  y1:3,   x2:8,   y2:5,   x3:9,   y3:4,   gsr:2, lx:8,   hx:10,  ly:3,   hy:5,   n:9,   col:2};
    repeat (2) @(negedge clk);
    chk("rst_valid", frag_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", prim_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_xy", {frag_x, frag_y}, 0);
    chk("rst_col", frag_col, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run(vecs[i], 1'b0);
    run(vecs[1], 1'b1);
    // Two primitives fill the FIFO while the consumer stalls; a third is dropped.
    frag_ready = 1'b0;
    push(vecs[1]);
    chk("stall_one", stall, 0);
    push(vecs[0]);
    chk("stall_full", stall, 1);
    push(vecs[4]);
    chk("overflow_set", overflow, 1);
    chk("stall_hold", stall, 1);
    scan(vecs[1], 1'b0);
    scan(vecs[0], 1'b0);
    idle_check("dropped_not_rastered", 10);
    chk("overflow_sticky", overflow, 1);
    chk("stall_drained", stall, 0);
    frag_ready = 1'b0;
    push(vecs[1]);
    push(vecs[0]);
    push(vecs[4]);
    chk("overflow_again", overflow, 1);
    wait_valid();
    chk("flush_pre_valid", frag_valid, 1);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    chk("flush_valid", frag_valid, 0);
    chk("flush_stall", stall, 0);
    chk("flush_ovf", overflow, 0);
    idle_check("flush_empty", 8);
    push(vecs[1]);
    wait_valid();
    chk("rst_pre_valid", frag_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", frag_valid, 0);
    chk("async_rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("rst_idle", 6);
    run(vecs[0], 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
